i2s_tx_param: RTL and testbench

Parametrised I2S-family serial audio transmitter. It is the next generation of the fixed 24-bit/48 kHz I2S master. It adds configurable sample width, slot width and SCLK divide ratio, plus run-time selection of I2S, left-justified or right-justified format. Samples arrive through a valid/ready stereo interface with a one-deep holding register, and underrun is reported. The block sits between the synth mixer output and the DAC pins, in the clk_audio domain.

---
 rtl/i2s_tx_param.sv | 150 +++++++++++++++
 tb/tb_i2s_tx_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_param.sv
// rtl/i2s_tx_param.sv - parametrised I2S / left- / right-justified stereo transmitter
// One-deep holding register feeds the per-frame shift registers at each frame boundary.
module i2s_tx_param #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 4
) (
  input  logic              clk_audio,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        fmt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_sclk,
  output logic              i2s_lrclk,
  output logic              i2s_dout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_W);
  localparam int PW = BW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);
  localparam logic [PW-1:0] OFS_I2S  = PW'(1);
  localparam logic [PW-1:0] OFS_RJ   = PW'(SLOT_W - DATA_W);
  localparam logic [PW-1:0] DATA_LEN = PW'(DATA_W);
  localparam logic [1:0]    FMT_LJ   = 2'd1;
  localparam logic [1:0]    FMT_RJ   = 2'd2;

  logic [DW-1:0]     r_div_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_sreg_l;
  logic [DATA_W-1:0] r_sreg_r;
  logic [1:0]        r_fmt;

  logic              w_div_wrap;
  logic              w_boundary;
  logic              w_accept;
  logic              w_slot;
  logic [PW-1:0]     w_pos;
  logic [PW-1:0]     w_ofs;
  logic [PW-1:0]     w_rel;
  logic              w_in_data;
  logic [DATA_W-1:0] w_sreg;
  logic [DATA_W-1:0] w_shifted;
  logic              w_dout;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_boundary = en && w_div_wrap && (r_bit_cnt == BIT_LAST);
  assign w_accept   = s_valid && !r_hold_full;
  assign s_ready    = !r_hold_full;

  // Bit position within the current slot, then relative to where the sample starts.
  assign w_slot = (r_bit_cnt >= SLOT_LEN);
  assign w_pos  = w_slot ? PW'(r_bit_cnt - SLOT_LEN) : PW'(r_bit_cnt);

  always_comb begin
    w_ofs = OFS_I2S;
    case (r_fmt)
      FMT_LJ:  w_ofs = '0;
      FMT_RJ:  w_ofs = OFS_RJ;
      default: w_ofs = OFS_I2S;
    endcase
  end

  assign w_rel     = w_pos - w_ofs;
  assign w_in_data = (w_pos >= w_ofs) && (w_rel < DATA_LEN);
  assign w_sreg    = w_slot ? r_sreg_r : r_sreg_l;
  assign w_shifted = w_sreg << w_rel;
  assign w_dout    = w_in_data && w_shifted[DATA_W-1];

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // Accept and unload are mutually exclusive because s_ready is low while full.
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (w_boundary && r_hold_full) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= s_left;
      r_hold_r    <= s_right;
    end
  end

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      r_sreg_l <= '0;
      r_sreg_r <= '0;
      r_fmt    <= '0;
    end else if (!en) begin
      r_sreg_l <= '0;
      r_sreg_r <= '0;
    end else if (w_boundary) begin
      r_sreg_l <= r_hold_full ? r_hold_l : '0;
      r_sreg_r <= r_hold_full ? r_hold_r : '0;
      r_fmt    <= fmt;
    end
  end

  // Pins are registered from the counters, so they trail them by one cycle.
  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      i2s_sclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (!en) begin
      i2s_sclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      i2s_sclk    <= (r_div_cnt >= DIV_HALF);
      i2s_lrclk   <= w_slot;
      i2s_dout    <= w_dout;
      frame_start <= w_boundary;
      underrun    <= w_boundary && !r_hold_full;
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// tb/tb_i2s_tx_param.sv - scoreboard bench for i2s_tx_param
// Stimulus pushes one expected frame per boundary; the monitor decodes pins per frame_start.
module tb_i2s_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, s_valid, s_ready, sclk, lrclk, dout, fs, und;
  logic [1:0]  fmt;
  logic [23:0] s_left, s_right;
  logic        en2, s_valid2, s_ready2, sclk2, lrclk2, dout2, fs2, und2;
  logic [1:0]  fmt2;
  logic [23:0] l2, r2;

  i2s_tx_param #(.DATA_W(24), .SLOT_W(32), .MCLK_DIV(4)) u_dut (
    .clk_audio(clk), .reset(reset), .en(en), .fmt(fmt),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .i2s_sclk(sclk), .i2s_lrclk(lrclk), .i2s_dout(dout),
    .frame_start(fs), .underrun(und)
  );

  i2s_tx_param #(.DATA_W(24), .SLOT_W(32), .MCLK_DIV(2)) u_dut2 (
    .clk_audio(clk), .reset(reset), .en(en2), .fmt(fmt2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_left(l2), .s_right(r2),
    .i2s_sclk(sclk2), .i2s_lrclk(lrclk2), .i2s_dout(dout2),
    .frame_start(fs2), .underrun(und2)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [1:0]  f;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        und;
  } rec_t;

  vec_t vecs[6];
  rec_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   frames_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_vec(input int i);
    rec_t r;
    r.l = vecs[i].el;
    r.r = vecs[i].er;
    r.und = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic push_und();
    rec_t r;
    r.l = '0;
    r.r = '0;
    r.und = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic load(input int i);
    s_left  = vecs[i].l;
    s_right = vecs[i].r;
  endtask

  task automatic send(input int i);
    int k = 0;
    load(i);
    s_valid = 1'b1;
    while (!s_ready && k < 600) begin
      tick(1);
      k++;
    end
    tick(1);
    s_valid = 1'b0;
    if (k >= 600) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin
      tick(1);
      k++;
    end while (!fs && k < 400);
    chk("frame_start_seen", fs, 1);
  endtask

  // Caller has just released reset or raised en at this negedge.
  task automatic first_frame();
    int k = 0;
    int lr_k = 0;
    bit nz = 0;
    do begin
      tick(1);
      k++;
      s_valid = 1'b0;
      if (dout) nz = 1;
      if (lrclk && lr_k == 0) lr_k = k;
    end while (!fs && k < 400);
    chk("first_frame_zero", nz, 0);
    chk("lrclk_rise_cycle", lr_k, 129);
    chk("first_boundary_cycle", k, 256);
  endtask

  initial begin
    bit coll = 0;
    bit prev = 0;
    bit lr_bad = 0;
    int idx = 0;
    logic [63:0] cap = '0;
    rec_t cur;
    forever begin
      @(negedge clk);
      if (reset || !en) begin
        coll = 0;
      end else if (fs) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("underrun_at_boundary", und, cur.und);
          coll = 1;
          idx = 0;
          cap = '0;
          lr_bad = 0;
          prev = sclk;
        end
      end else if (coll) begin
        if (sclk && !prev) begin
          cap[63-idx] = dout;
          if (lrclk != (idx >= 32)) lr_bad = 1;
          idx++;
          if (idx == 64) begin
            chk("frame_bits", cap, {cur.l, cur.r});
            chk("lrclk_slot", lr_bad, 0);
            coll = 0;
            frames_done++;
          end
        end
        prev = sclk;
      end
    end
  end

  initial begin
    int k;
    int j;
    int n;
    int rise1;
    int rise2;
    bit quiet;
    logic [63:0] cap2;

    vecs[0] = '{24'h800001, 24'h7FFFFE, 2'd0, 32'h40000080, 32'h3FFFFF00};
    vecs[1] = '{24'hA5A5A5, 24'h123456, 2'd1, 32'hA5A5A500, 32'h12345600};
    vecs[2] = '{24'hFFFFFF, 24'h000001, 2'd2, 32'h00FFFFFF, 32'h00000001};
    vecs[3] = '{24'h0F0F0F, 24'hC00003, 2'd3, 32'h07878780, 32'h60000180};
    vecs[4] = '{24'h800000, 24'hFFFFFF, 2'd0, 32'h40000000, 32'h7FFFFF80};
    vecs[5] = '{24'h5A5A5A, 24'h00FF00, 2'd1, 32'h5A5A5A00, 32'h00FF0000};

    reset = 1'b1; en = 1'b0; fmt = 2'd0; s_valid = 1'b0; s_left = '0; s_right = '0;
    en2 = 1'b0; fmt2 = 2'd0; s_valid2 = 1'b0; l2 = '0; r2 = '0;
    tick(3);
    chk("reset_pins", {sclk, lrclk, dout, fs, und}, 0);
    chk("reset_ready", s_ready, 1);
    chk("reset_ready2", s_ready2, 1);

    // Run ~100 cycles with a held sample, then reset asynchronously mid-frame.
    reset = 1'b0; en = 1'b1; s_left = 24'h123123; s_right = 24'h321321; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    tick(98);
    k = 0;
    while (!sclk && k < 8) begin
      tick(1);
      k++;
    end
    chk("pre_reset_held", s_ready, 0);
    chk("pre_reset_sclk", sclk, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pins", {sclk, lrclk, dout, fs, und}, 0);
    chk("async_reset_ready", s_ready, 1);
    tick(2);

    reset = 1'b0; fmt = vecs[0].f; load(0); s_valid = 1'b1;
    push_vec(0);
    first_frame();

    fmt = vecs[1].f; send(1); push_vec(1);
    wait_fs();
    fmt = vecs[2].f; send(2); push_vec(2);
    wait_fs();

    // Back-to-back: fmt change mid-frame must not disturb the frame in flight.
    fmt = vecs[3].f; load(3); s_valid = 1'b1; push_vec(3);
    tick(1);
    load(4);
    chk("stall_ready_low", s_ready, 0);
    k = 0;
    while (!s_ready && k < 400) begin
      tick(1);
      k++;
    end
    chk("stall_ends_at_boundary", fs, 1);
    tick(1);
    s_valid = 1'b0; fmt = vecs[4].f; push_vec(4);
    wait_fs();
    push_und();
    wait_fs();
    push_und();
    wait_fs();

    tick(40);
    k = 0;
    while (!sclk && k < 8) begin
      tick(1);
      k++;
    end
    en = 1'b0;
    tick(1);
    chk("en_low_pins", {sclk, lrclk, dout}, 0);
    fmt = vecs[5].f;
    send(5);
    chk("held_while_idle", s_ready, 0);
    quiet = 0;
    repeat (50) begin
      tick(1);
      if (fs || und || sclk || dout || lrclk) quiet = 1;
    end
    chk("idle_quiet", quiet, 0);
    push_vec(5);
    en = 1'b1;
    first_frame();
    push_und();
    k = 0;
    while (frames_done < 7 && k < 400) begin
      tick(1);
      k++;
    end
    chk("frames_checked", frames_done, 7);
    en = 1'b0;

    // MCLK_DIV=2 instance: right-justified sample, 2-cycle SCLK, 128-cycle frame.
    fmt2 = 2'd2; l2 = 24'hFFFFFF; r2 = 24'h000000; s_valid2 = 1'b1;
    tick(1);
    s_valid2 = 1'b0; en2 = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!fs2 && k < 300);
    chk("div2_frame_cycles", k, 128);
    chk("div2_underrun", und2, 0);
    quiet = sclk2;
    cap2 = '0; n = 0; j = 0; rise1 = 0; rise2 = 0;
    while (n < 64 && j < 300) begin
      tick(1);
      j++;
      if (sclk2 && !quiet) begin
        cap2[63-n] = dout2;
        n++;
        if (n == 1) rise1 = j;
        if (n == 2) rise2 = j;
      end
      quiet = sclk2;
    end
    chk("div2_sclk_period", rise2 - rise1, 2);
    chk("div2_frame_bits", cap2, 64'h00FFFFFF_00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
